// File: rtl/pixel_pattern_gen.sv
// Test-pattern generator behind vga_controller: solid, colour bars, checkerboard
// and a bouncing box, delivered through a two-stage colour/sync pipeline.
module pixel_pattern_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080,
    parameter int BOX_SIZE = 64,
    parameter int SPEED    = 2
) (
    input  logic        clk_148Mhz,
    input  logic        reset,
    input  logic [11:0] h_count_reg,
    input  logic [11:0] v_count_reg,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] sw,
    input  logic [1:0]  mode,
    output logic [3:0]  vgaRed,
    output logic [3:0]  vgaGreen,
    output logic [3:0]  vgaBlue,
    output logic        hsync,
    output logic        vsync
);

    typedef enum logic [1:0] {
        MODE_SOLID = 2'b00,
        MODE_BARS  = 2'b01,
        MODE_CHECK = 2'b10,
        MODE_BOX   = 2'b11
    } mode_e;

    localparam logic [10:0] X_LIM   = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] Y_LIM   = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [11:0] V_BLANK = 12'(V_ACTIVE);
    localparam logic [11:0] BOX_W   = 12'(BOX_SIZE);
    localparam logic [11:0] STEP    = 12'(SPEED);
    localparam logic [11:0] BOX_BG  = 12'h222;
    localparam logic [11:0] BAR1    = 12'(1 * H_ACTIVE / 8);
    localparam logic [11:0] BAR2    = 12'(2 * H_ACTIVE / 8);
    localparam logic [11:0] BAR3    = 12'(3 * H_ACTIVE / 8);
    localparam logic [11:0] BAR4    = 12'(4 * H_ACTIVE / 8);
    localparam logic [11:0] BAR5    = 12'(5 * H_ACTIVE / 8);
    localparam logic [11:0] BAR6    = 12'(6 * H_ACTIVE / 8);
    localparam logic [11:0] BAR7    = 12'(7 * H_ACTIVE / 8);

    // Returns {new_dir, new_pos}; clamps at the wall so the position never leaves [0, lim].
    function automatic logic [11:0] axis_step(input logic [10:0] pos,
                                              input logic        dir,
                                              input logic [10:0] lim);
        logic [11:0] pos_w;
        pos_w = {1'b0, pos};
        if (dir) begin
            if (pos_w + STEP >= {1'b0, lim}) begin
                axis_step = {1'b0, lim};
            end else begin
                pos_w     = pos_w + STEP;
                axis_step = {1'b1, pos_w[10:0]};
            end
        end else begin
            if (pos_w <= STEP) begin
                axis_step = {1'b1, 11'd0};
            end else begin
                pos_w     = pos_w - STEP;
                axis_step = {1'b0, pos_w[10:0]};
            end
        end
    endfunction

    function automatic logic [11:0] bar_colour(input logic [11:0] h);
        if (h < BAR1) begin
            bar_colour = 12'hFFF;
        end else if (h < BAR2) begin
            bar_colour = 12'hFF0;
        end else if (h < BAR3) begin
            bar_colour = 12'h0FF;
        end else if (h < BAR4) begin
            bar_colour = 12'h0F0;
        end else if (h < BAR5) begin
            bar_colour = 12'hF0F;
        end else if (h < BAR6) begin
            bar_colour = 12'hF00;
        end else if (h < BAR7) begin
            bar_colour = 12'h00F;
        end else begin
            bar_colour = 12'h000;
        end
    endfunction

    mode_e       mode_q, mode_d;
    logic [10:0] box_x_q, box_x_d, box_y_q, box_y_d;
    logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [11:0] col1_q, col1_d, col2_q, col2_d;
    logic        von1_q, hs1_q, vs1_q, hs2_q, vs2_q;
    logic        frame_tick_s, in_box_s;
    logic [11:0] x_step_s, y_step_s;

    // Frame-rate control: mode latch and box motion advance only on frame_tick.
    always_comb begin
        frame_tick_s = (h_count_reg == 12'd0) && (v_count_reg == V_BLANK);
        x_step_s     = axis_step(box_x_q, dir_x_q, X_LIM);
        y_step_s     = axis_step(box_y_q, dir_y_q, Y_LIM);
        mode_d       = mode_q;
        box_x_d      = box_x_q;
        box_y_d      = box_y_q;
        dir_x_d      = dir_x_q;
        dir_y_d      = dir_y_q;
        if (frame_tick_s) begin
            mode_d             = mode_e'(mode);
            {dir_x_d, box_x_d} = x_step_s;
            {dir_y_d, box_y_d} = y_step_s;
        end else begin
            mode_d = mode_q;
        end
    end

    // Stage-1 pattern select from the raw counters; stage 2 blanks outside the active area.
    always_comb begin
        in_box_s = (h_count_reg >= {1'b0, box_x_q}) && (h_count_reg < {1'b0, box_x_q} + BOX_W) &&
                   (v_count_reg >= {1'b0, box_y_q}) && (v_count_reg < {1'b0, box_y_q} + BOX_W);
        col1_d   = 12'h000;
        case (mode_q)
            MODE_SOLID: col1_d = sw;
            MODE_BARS:  col1_d = bar_colour(h_count_reg);
            MODE_CHECK: col1_d = (h_count_reg[6] ^ v_count_reg[6]) ? sw : 12'h000;
            MODE_BOX:   col1_d = in_box_s ? sw : BOX_BG;
            default:    col1_d = 12'h000;
        endcase
        if (von1_q) begin
            col2_d = col1_q;
        end else begin
            col2_d = 12'h000;
        end
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk_148Mhz) begin
        if (reset) begin
            mode_q  <= MODE_SOLID;
            box_x_q <= 11'd0;
            box_y_q <= 11'd0;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
            col1_q  <= 12'h000;
            von1_q  <= 1'b0;
            hs1_q   <= 1'b0;
            vs1_q   <= 1'b0;
            col2_q  <= 12'h000;
            hs2_q   <= 1'b0;
            vs2_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            box_x_q <= box_x_d;
            box_y_q <= box_y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
            col1_q  <= col1_d;
            von1_q  <= video_on;
            hs1_q   <= hsync_in;
            vs1_q   <= vsync_in;
            col2_q  <= col2_d;
            hs2_q   <= hs1_q;
            vs2_q   <= vs1_q;
        end
    end

    assign vgaRed   = col2_q[11:8];
    assign vgaGreen = col2_q[7:4];
    assign vgaBlue  = col2_q[3:0];
    assign hsync    = hs2_q;
    assign vsync    = vs2_q;

endmodule

// File: tb/tb_pixel_pattern_gen.sv
// Directed bench for pixel_pattern_gen: a behavioural model pushes expected
// {colour, hsync, vsync} per cycle into a queue that is checked two cycles later.
module tb_pixel_pattern_gen;

    logic        clk_148Mhz = 1'b0;
    logic        reset;
    logic [11:0] h_count_reg, v_count_reg, sw;
    logic        video_on, hsync_in, vsync_in;
    logic [1:0]  mode;
    logic [3:0]  vgaRed, vgaGreen, vgaBlue;
    logic        hsync, vsync;

    typedef struct {
        logic [13:0] exp;
        string       tag;
    } rec_t;

    rec_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model state
    int   m_mode, bx, by;
    logic dx, dy;

    pixel_pattern_gen dut (
        .clk_148Mhz (clk_148Mhz),
        .reset      (reset),
        .h_count_reg(h_count_reg),
        .v_count_reg(v_count_reg),
        .video_on   (video_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .sw         (sw),
        .mode       (mode),
        .vgaRed     (vgaRed),
        .vgaGreen   (vgaGreen),
        .vgaBlue    (vgaBlue),
        .hsync      (hsync),
        .vsync      (vsync)
    );

    always #5 clk_148Mhz = ~clk_148Mhz;

    function automatic logic [11:0] model_col(input int h, input int v, input logic von);
        logic [11:0] bars [8];
        logic [11:0] c;
        bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        case (m_mode)
            0: c = sw;
            1: c = bars[h / 240];
            2: c = ((((h >> 6) & 1) ^ ((v >> 6) & 1)) != 0) ? sw : 12'h000;
            default: c = (h >= bx && h < bx + 64 && v >= by && v < by + 64) ? sw : 12'h222;
        endcase
        return von ? c : 12'h000;
    endfunction

    task automatic model_reset();
        m_mode = 0; bx = 0; by = 0; dx = 1'b1; dy = 1'b1;
    endtask

    task automatic model_tick();
        m_mode = int'(mode);
        if (dx) begin
            if (bx + 2 >= 1856) begin bx = 1856; dx = 1'b0; end
            else bx = bx + 2;
        end else begin
            if (bx <= 2) begin bx = 0; dx = 1'b1; end
            else bx = bx - 2;
        end
        if (dy) begin
            if (by + 2 >= 1016) begin by = 1016; dy = 1'b0; end
            else by = by + 2;
        end else begin
            if (by <= 2) begin by = 0; dy = 1'b1; end
            else by = by - 2;
        end
    endtask

    task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int h, input int v, input logic von, input logic hs,
                        input logic vs, input string tag);
        rec_t r;
        h_count_reg = 12'(h);
        v_count_reg = 12'(v);
        video_on    = von;
        hsync_in    = hs;
        vsync_in    = vs;
        r.exp = {model_col(h, v, von), hs, vs};
        r.tag = tag;
        q.push_back(r);
        if (h == 0 && v == 1080) model_tick();
        @(posedge clk_148Mhz);
        #1;
        if (q.size() >= 2) begin
            r = q.pop_front();
            check(r.tag, {vgaRed, vgaGreen, vgaBlue, hsync, vsync}, r.exp);
        end
    endtask

    task automatic do_reset(input int n);
        rec_t r;
        reset = 1'b1;
        q.delete();
        for (int i = 0; i < n; i++) begin
            @(posedge clk_148Mhz);
            #1;
            check("rst_out", {vgaRed, vgaGreen, vgaBlue, hsync, vsync}, 14'h0000);
        end
        model_reset();
        reset = 1'b0;
        r.exp = 14'h0000;
        r.tag = "rst_release";
        q.push_back(r);
    endtask

    task automatic check_box(input string tag);
        check({tag, "_x"},    14'(dut.box_x_q), 14'(bx));
        check({tag, "_y"},    14'(dut.box_y_q), 14'(by));
        check({tag, "_dirx"}, 14'(dut.dir_x_q), 14'(dx));
        check({tag, "_diry"}, 14'(dut.dir_y_q), 14'(dy));
    endtask

    initial begin
        reset = 1'b1; h_count_reg = 12'd0; v_count_reg = 12'd0; video_on = 1'b0;
        hsync_in = 1'b0; vsync_in = 1'b0; sw = 12'hA5C; mode = 2'b00;
        model_reset();
        do_reset(2);

        // Solid colour and video_on gating
        step(100, 100, 1'b1, 1'b0, 1'b0, "solid_on");
        step(100, 100, 1'b0, 1'b0, 1'b0, "solid_off");
        step(101, 100, 1'b1, 1'b1, 1'b0, "solid_hs");
        step(102, 100, 1'b1, 1'b0, 1'b1, "solid_vs");

        // Colour bars, latched on a frame tick
        mode = 2'b01;
        step(0, 1080, 1'b0, 1'b0, 1'b1, "tick_bars");
        step(239,  10, 1'b1, 1'b1, 1'b0, "bar_239");
        step(240,  10, 1'b1, 1'b0, 1'b1, "bar_240");
        step(1919, 10, 1'b1, 1'b1, 1'b1, "bar_1919");
        step(480,  10, 1'b1, 1'b0, 1'b0, "bar_480");
        step(1200, 10, 1'b1, 1'b1, 1'b0, "bar_1200");
        step(1679, 10, 1'b1, 1'b0, 1'b1, "bar_1679");

        // Mid-frame mode change is held until the next frame
        mode = 2'b00;
        step(0, 1080, 1'b0, 1'b0, 1'b0, "tick_solid");
        step(10, 500, 1'b1, 1'b1, 1'b1, "latch_pre");
        mode = 2'b10;
        step(64, 500,  1'b1, 1'b0, 1'b0, "latch_v500");
        step(64, 1079, 1'b1, 1'b0, 1'b0, "latch_v1079");
        step(0,  1079, 1'b1, 1'b0, 1'b0, "latch_v1079_h0");
        step(0,  1080, 1'b0, 1'b0, 1'b1, "tick_check");
        step(64, 0,    1'b1, 1'b0, 1'b0, "check_h64");
        step(0,  0,    1'b1, 1'b0, 1'b0, "check_h0");
        step(64, 64,   1'b1, 1'b0, 1'b0, "check_both");
        step(0,  64,   1'b1, 1'b0, 1'b0, "check_v64");

        // Reset mid-frame restores box and mode
        step(899, 600, 1'b1, 1'b1, 1'b1, "pre_reset");
        h_count_reg = 12'd900; v_count_reg = 12'd600;
        do_reset(1);
        check_box("rst_box");
        check("rst_mode", 14'(dut.mode_q), 14'd0);
        step(5, 600, 1'b1, 1'b1, 1'b0, "post_rst_a");
        step(6, 600, 1'b1, 1'b0, 1'b1, "post_rst_b");
        step(7, 600, 1'b1, 1'b0, 1'b0, "post_rst_c");

        // Bouncing box
        mode = 2'b11;
        sw   = 12'hF00;
        step(0, 1080, 1'b0, 1'b0, 1'b0, "tick_1");
        check_box("box_t1");
        step(2,  2,  1'b1, 1'b0, 1'b0, "box_tl");
        step(1,  2,  1'b1, 1'b0, 1'b0, "box_left");
        step(65, 65, 1'b1, 1'b0, 1'b0, "box_br");
        step(66, 65, 1'b1, 1'b0, 1'b0, "box_right");
        step(65, 66, 1'b1, 1'b0, 1'b0, "box_below");
        for (int i = 2; i <= 928; i++) step(0, 1080, 1'b0, 1'b0, 1'b0, "tick_n");
        check_box("box_t928");
        step(0, 1080, 1'b0, 1'b0, 1'b0, "tick_929");
        check_box("box_t929");
        step(bx,      by,      1'b1, 1'b0, 1'b0, "box929_tl");
        step(bx + 63, by + 63, 1'b1, 1'b0, 1'b0, "box929_br");
        step(bx - 1,  by,      1'b1, 1'b0, 1'b0, "box929_left");
        step(bx + 63, by + 64, 1'b1, 1'b0, 1'b0, "box929_below");
        step(1, 1, 1'b0, 1'b0, 1'b0, "drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_pattern_gen.md
PIXEL_PATTERN_GEN -- requirements
Module: pixel_pattern_gen

Interface
REQ-001 Parameter H_ACTIVE, default 1920: active pixels per line.
REQ-002 Parameter V_ACTIVE, default 1080: active lines per frame.
REQ-003 Parameter BOX_SIZE, default 64: bouncing-box edge length, pixels.
REQ-004 Parameter SPEED, default 2: box displacement per frame per axis, pixels.
REQ-005 Port clk_148Mhz, input, 1: sole clock, the 148.5 MHz pixel clock.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port h_count_reg, input, 12: horizontal pixel counter from vga_controller.
REQ-008 Port v_count_reg, input, 12: vertical line counter from vga_controller.
REQ-009 Port video_on, input, 1: active-area flag from vga_controller.
REQ-010 Port hsync_in / vsync_in, input, 1 each: raw syncs from vga_controller.
REQ-011 Port sw, input, 12: foreground colour, {R[11:8], G[7:4], B[3:0]}.
REQ-012 Port mode, input, 2: pattern select.
REQ-013 Port vgaRed / vgaGreen / vgaBlue, output, 4 each: registered pixel colour.
REQ-014 Port hsync / vsync, output, 1 each: syncs delayed to align with colour.

Function
REQ-015 Pipeline SHALL be two register stages; colour, hsync and vsync outputs SHALL appear exactly 2 clk_148Mhz cycles after the inputs that produced them.
REQ-016 The delayed video_on SHALL gate colour: when low, all colour outputs SHALL be 0x0.
REQ-017 frame_tick SHALL pulse for one cycle when h_count_reg==0 and v_count_reg==V_ACTIVE, i.e. the first blanking line.
REQ-018 mode SHALL be latched into mode_q only on frame_tick; mid-frame changes SHALL take effect from the next frame.
REQ-019 mode_q=00, solid: every active pixel = sw.
REQ-020 mode_q=01, colour bars: 8 bars of H_ACTIVE/8 = 240 px, left to right FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000; bar index by threshold compares, no divider.
REQ-021 mode_q=10, checkerboard: pixel = sw when h_count_reg[6] XOR v_count_reg[6] is 1, else 000.
REQ-022 mode_q=11, bouncing box: pixel = sw when box_x <= h < box_x+BOX_SIZE and box_y <= v < box_y+BOX_SIZE, else 222.
REQ-023 Box state SHALL be box_x, box_y (11 bits each) and dir_x, dir_y (1 = increasing); it SHALL update only on frame_tick, in every mode.
REQ-024 X update: moving right, if box_x + SPEED >= H_ACTIVE-BOX_SIZE (1856), then box_x = 1856 and dir_x = 0; otherwise box_x += SPEED.
REQ-025 X update: moving left, if box_x <= SPEED, then box_x = 0 and dir_x = 1; otherwise box_x -= SPEED.
REQ-026 Y axis SHALL follow the same rules with limit V_ACTIVE-BOX_SIZE (1016).
REQ-027 Box position SHALL never leave [0,1856] x [0,1016], so no arithmetic underflow or overflow is possible.
REQ-028 Inputs outside the active area SHALL not affect box state except via frame_tick.

Reset
REQ-029 Synchronous reset SHALL clear both pipeline stages, so colour, hsync and vsync outputs are 0 on the first edge with reset high.
REQ-030 Synchronous reset SHALL set box_x=0, box_y=0, dir_x=1, dir_y=1 and mode_q=00.
REQ-031 Reset asserted mid-frame SHALL take effect on the next edge.
REQ-032 Outputs SHALL stay 0 for 2 cycles after reset release, then follow inputs with normal latency; box motion SHALL resume at the next frame_tick.

Verification
REQ-033 Solid: mode=00, sw=0xA5C, video_on=1 at h=100, v=100 -> two cycles later {R,G,B}=A,5,C; video_on=0 -> 0,0,0.
REQ-034 Bars: mode=01 latched; h=239 -> FFF; h=240 -> FF0; h=1919 -> 000; sync outputs equal hsync_in/vsync_in delayed 2 cycles.
REQ-035 Latch: switch mode 00->10 at v=500 -> output stays solid through v=1079; checkerboard from next frame (h=64, v=0 -> sw).
REQ-036 Bounce: after reset, 1 frame_tick -> box (2,2); after 928 frame_ticks -> box_x=1856, dir_x=0; after 929 -> box_x=1854.
REQ-037 Box edge: box at (0,0), mode=11, sw=0xF00 -> h=63, v=63 is F00; h=64, v=63 is 222.
REQ-038 Reset mid-frame at h=900, v=600 -> outputs 0 next edge; box (0,0); mode_q=00.
